// File: rtl/udp_pkg.sv
// Shared definitions for the UDP checksum checker.
// Contents: bus widths, pseudo-header constants, FSM state enum, header payload
// struct and the helpers that build the checksum seed and payload words.
package udp_pkg;

   localparam int unsigned IP_W   = 32;
   localparam int unsigned PORT_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned CSUM_W = 16;

   // Protocol number carried in the IPv4 pseudo-header for UDP
   localparam logic [CSUM_W-1:0] IP_PROTO_UDP = 16'h0011;
   // Size of the fixed UDP header in bytes
   localparam logic [CSUM_W-1:0] UDP_HDR_LEN  = 16'd8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } udp_state_e;

   typedef struct packed {
      logic [IP_W-1:0]   src_ip;
      logic [IP_W-1:0]   dst_ip;
      logic [PORT_W-1:0] src_port;
      logic [PORT_W-1:0] dst_port;
      logic [PORT_W-1:0] length;
      logic [CSUM_W-1:0] checksum;
   } udp_hdr_t;

   // Pseudo-header plus UDP header words. The length appears twice: once in
   // the pseudo-header and once in the UDP header itself.
   function automatic logic [ACC_W-1:0] pseudo_hdr_seed(input udp_hdr_t h);
      logic [ACC_W-1:0] s;
      s = ACC_W'(h.src_ip[31:16]) + ACC_W'(h.src_ip[15:0])
        + ACC_W'(h.dst_ip[31:16]) + ACC_W'(h.dst_ip[15:0])
        + ACC_W'(IP_PROTO_UDP)
        + ACC_W'({h.length, 1'b0})
        + ACC_W'(h.src_port) + ACC_W'(h.dst_port)
        + ACC_W'(h.checksum);
      return s;
   endfunction

   // Even byte positions are the high half of a 16-bit word, odd ones the low half
   function automatic logic [CSUM_W-1:0] payload_word(input logic [DATA_W-1:0] b,
                                                      input logic              odd);
      return odd ? {8'h00, b} : {b, 8'h00};
   endfunction

endpackage

// File: rtl/ones_comp_fold.sv
// One's-complement end-around-carry fold of a 32-bit running sum to 16 bits.
// Ports:
//   sum_in - 32-bit accumulator value
//   fold_c - 16-bit folded result (combinational)
module ones_comp_fold
   import udp_pkg::*;
(
   input  logic [ACC_W-1:0]  sum_in,
   output logic [CSUM_W-1:0] fold_c
);

   logic [16:0] fold1;

   // First fold leaves at most one carry (max 0x1FFFE); adding it back cannot carry again
   always_comb begin
      fold1  = 17'(sum_in[31:16]) + 17'(sum_in[15:0]);
      fold_c = fold1[15:0] + 16'(fold1[16]);
   end

endmodule

// File: rtl/udp_checksum_check.sv
// UDP receive checksum checker.
// Accepts a UDP header, forwards it as a registered copy, then streams the
// payload through a one-entry output register while summing it into a
// one's-complement accumulator seeded with the pseudo-header. On the final
// beat the frame is marked bad (tuser) and an error pulse is raised when the
// checksum does not verify.
//
// Optional feature: define UDP_CHECKSUM_CHECK_LEN_EN to also compare the
// received payload byte count against udp_length-8 and raise error_length.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   s_udp_hdr_*, s_ip_*        - input header handshake and fields
//   m_udp_hdr_*, m_ip_*        - output header handshake and registered fields
//   s_udp_payload_axis_*       - input payload byte stream
//   m_udp_payload_axis_*       - output payload byte stream (tuser marks bad frame)
//   error_checksum             - one-cycle pulse on checksum mismatch
//   error_length               - one-cycle pulse on length mismatch
//   busy                       - frame in progress
module udp_checksum_check
   import udp_pkg::*;
#(
   parameter bit ZERO_CSUM_OK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              s_udp_hdr_valid,
   output logic              s_udp_hdr_ready,
   input  logic [IP_W-1:0]   s_ip_source_ip,
   input  logic [IP_W-1:0]   s_ip_dest_ip,
   input  logic [PORT_W-1:0] s_udp_source_port,
   input  logic [PORT_W-1:0] s_udp_dest_port,
   input  logic [PORT_W-1:0] s_udp_length,
   input  logic [CSUM_W-1:0] s_udp_checksum,

   output logic              m_udp_hdr_valid,
   input  logic              m_udp_hdr_ready,
   output logic [IP_W-1:0]   m_ip_source_ip,
   output logic [IP_W-1:0]   m_ip_dest_ip,
   output logic [PORT_W-1:0] m_udp_source_port,
   output logic [PORT_W-1:0] m_udp_dest_port,
   output logic [PORT_W-1:0] m_udp_length,
   output logic [CSUM_W-1:0] m_udp_checksum,

   input  logic [DATA_W-1:0] s_udp_payload_axis_tdata,
   input  logic              s_udp_payload_axis_tvalid,
   output logic              s_udp_payload_axis_tready,
   input  logic              s_udp_payload_axis_tlast,
   input  logic              s_udp_payload_axis_tuser,

   output logic [DATA_W-1:0] m_udp_payload_axis_tdata,
   output logic              m_udp_payload_axis_tvalid,
   input  logic              m_udp_payload_axis_tready,
   output logic              m_udp_payload_axis_tlast,
   output logic              m_udp_payload_axis_tuser,

   output logic              error_checksum,
   output logic              error_length,
   output logic              busy
);

   udp_state_e        state_q, state_d;
   udp_hdr_t          hdr_q, hdr_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              odd_q, odd_d;
   logic              in_done_q, in_done_d;
   logic              hdr_ready_q, hdr_ready_d;
   logic              m_hdr_valid_q, m_hdr_valid_d;
   logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
   logic              m_tvalid_q, m_tvalid_d;
   logic              m_tlast_q, m_tlast_d;
   logic              m_tuser_q, m_tuser_d;
   logic              err_csum_q, err_csum_d;
   logic              err_len_q, err_len_d;

   udp_hdr_t          s_hdr_c;
   logic              hdr_acc_c;
   logic              out_ready_c;
   logic              s_tready_c;
   logic              beat_acc_c;
   logic              out_last_acc_c;
   logic [ACC_W-1:0]  acc_sum_c;
   logic [15:0]       cnt_inc_c;
   logic [CSUM_W-1:0] fold_c;
   logic              csum_bad_c;
   logic              len_bad_c;

   assign s_hdr_c = '{src_ip:   s_ip_source_ip,
                      dst_ip:   s_ip_dest_ip,
                      src_port: s_udp_source_port,
                      dst_port: s_udp_dest_port,
                      length:   s_udp_length,
                      checksum: s_udp_checksum};

   // Handshakes; input side stops after the last beat until the frame drains
   always_comb begin
      hdr_acc_c      = s_udp_hdr_valid && hdr_ready_q;
      out_ready_c    = !m_tvalid_q || m_udp_payload_axis_tready;
      s_tready_c     = (state_q == ST_PAYLOAD) && !in_done_q && out_ready_c;
      beat_acc_c     = s_udp_payload_axis_tvalid && s_tready_c;
      out_last_acc_c = m_tvalid_q && m_tlast_q && m_udp_payload_axis_tready;
   end

   // Running sum including the current beat, used on the last beat to verify
   assign acc_sum_c = acc_q + ACC_W'(payload_word(s_udp_payload_axis_tdata, odd_q));

   ones_comp_fold u_fold (
      .sum_in (acc_sum_c),
      .fold_c (fold_c)
   );

   assign cnt_inc_c  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // A transmitted checksum of zero means the sender did not compute one
   assign csum_bad_c = (fold_c != 16'hFFFF) &&
                       !(ZERO_CSUM_OK && (hdr_q.checksum == '0));

`ifdef UDP_CHECKSUM_CHECK_LEN_EN
   assign len_bad_c  = (hdr_q.length < UDP_HDR_LEN) ||
                       (cnt_inc_c != (hdr_q.length - UDP_HDR_LEN));
`else
   assign len_bad_c  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (hdr_acc_c)       state_d = ST_HDR;
         ST_HDR:     if (m_udp_hdr_ready) state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (out_last_acc_c)  state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      hdr_d         = hdr_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      odd_d         = odd_q;
      in_done_d     = in_done_q;
      hdr_ready_d   = (state_d == ST_IDLE);
      m_hdr_valid_d = (state_d == ST_HDR);
      m_tdata_d     = m_tdata_q;
      m_tvalid_d    = m_tvalid_q;
      m_tlast_d     = m_tlast_q;
      m_tuser_d     = m_tuser_q;
      err_csum_d    = 1'b0;
      err_len_d     = 1'b0;

      if (hdr_acc_c) begin
         hdr_d     = s_hdr_c;
         acc_d     = pseudo_hdr_seed(s_hdr_c);
         cnt_d     = '0;
         odd_d     = 1'b0;
         in_done_d = 1'b0;
      end

      if (m_udp_payload_axis_tready) begin
         m_tvalid_d = 1'b0;
      end

      if (beat_acc_c) begin
         acc_d      = acc_sum_c;
         cnt_d      = cnt_inc_c;
         odd_d      = !odd_q;
         m_tdata_d  = s_udp_payload_axis_tdata;
         m_tvalid_d = 1'b1;
         m_tlast_d  = s_udp_payload_axis_tlast;
         m_tuser_d  = s_udp_payload_axis_tuser;
         // Verdict rides out with the last beat; pulses align with its first output cycle
         if (s_udp_payload_axis_tlast) begin
            in_done_d  = 1'b1;
            m_tuser_d  = s_udp_payload_axis_tuser | csum_bad_c | len_bad_c;
            err_csum_d = csum_bad_c;
            err_len_d  = len_bad_c;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_q         <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         odd_q         <= 1'b0;
         in_done_q     <= 1'b0;
         hdr_ready_q   <= 1'b0;
         m_hdr_valid_q <= 1'b0;
         m_tdata_q     <= '0;
         m_tvalid_q    <= 1'b0;
         m_tlast_q     <= 1'b0;
         m_tuser_q     <= 1'b0;
         err_csum_q    <= 1'b0;
         err_len_q     <= 1'b0;
      end else begin
         hdr_q         <= hdr_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         odd_q         <= odd_d;
         in_done_q     <= in_done_d;
         hdr_ready_q   <= hdr_ready_d;
         m_hdr_valid_q <= m_hdr_valid_d;
         m_tdata_q     <= m_tdata_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tlast_q     <= m_tlast_d;
         m_tuser_q     <= m_tuser_d;
         err_csum_q    <= err_csum_d;
         err_len_q     <= err_len_d;
      end
   end

   assign s_udp_hdr_ready           = hdr_ready_q;
   assign m_udp_hdr_valid           = m_hdr_valid_q;
   assign m_ip_source_ip            = hdr_q.src_ip;
   assign m_ip_dest_ip              = hdr_q.dst_ip;
   assign m_udp_source_port         = hdr_q.src_port;
   assign m_udp_dest_port           = hdr_q.dst_port;
   assign m_udp_length              = hdr_q.length;
   assign m_udp_checksum            = hdr_q.checksum;
   assign s_udp_payload_axis_tready = s_tready_c;
   assign m_udp_payload_axis_tdata  = m_tdata_q;
   assign m_udp_payload_axis_tvalid = m_tvalid_q;
   assign m_udp_payload_axis_tlast  = m_tlast_q;
   assign m_udp_payload_axis_tuser  = m_tuser_q;
   assign error_checksum            = err_csum_q;
   assign error_length              = err_len_q;
   assign busy                      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_checksum_check.sv
`timescale 1ns/1ps
module tb_udp_checksum_check;

`ifdef UDP_CHECKSUM_CHECK_LEN_EN
   localparam bit LEN_EN = 1'b1;
`else
   localparam bit LEN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        s_hdr_valid;
   logic [31:0] s_src, s_dst;
   logic [15:0] s_sport, s_dport, s_len, s_csum;
   logic        m_hdr_ready;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tuser;
   logic        m_tready;

   // DUT with ZERO_CSUM_OK=1
   logic        s_hdr_ready, m_hdr_valid;
   logic [31:0] m_src, m_dst;
   logic [15:0] m_sport, m_dport, m_len, m_csum;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast, m_tuser;
   logic        err_c, err_l, busy;

   // DUT with ZERO_CSUM_OK=0
   logic        s_hdr_ready_z, m_hdr_valid_z;
   logic [31:0] m_src_z, m_dst_z;
   logic [15:0] m_sport_z, m_dport_z, m_len_z, m_csum_z;
   logic        s_tready_z;
   logic [7:0]  m_tdata_z;
   logic        m_tvalid_z, m_tlast_z, m_tuser_z;
   logic        err_c_z, err_l_z, busy_z;

   udp_checksum_check #(.ZERO_CSUM_OK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready),
      .s_ip_source_ip(s_src), .s_ip_dest_ip(s_dst),
      .s_udp_source_port(s_sport), .s_udp_dest_port(s_dport),
      .s_udp_length(s_len), .s_udp_checksum(s_csum),
      .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
      .m_ip_source_ip(m_src), .m_ip_dest_ip(m_dst),
      .m_udp_source_port(m_sport), .m_udp_dest_port(m_dport),
      .m_udp_length(m_len), .m_udp_checksum(m_csum),
      .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
      .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
      .s_udp_payload_axis_tuser(s_tuser),
      .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tvalid(m_tvalid),
      .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(m_tlast),
      .m_udp_payload_axis_tuser(m_tuser),
      .error_checksum(err_c), .error_length(err_l), .busy(busy)
   );

   udp_checksum_check #(.ZERO_CSUM_OK(1'b0)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready_z),
      .s_ip_source_ip(s_src), .s_ip_dest_ip(s_dst),
      .s_udp_source_port(s_sport), .s_udp_dest_port(s_dport),
      .s_udp_length(s_len), .s_udp_checksum(s_csum),
      .m_udp_hdr_valid(m_hdr_valid_z), .m_udp_hdr_ready(m_hdr_ready),
      .m_ip_source_ip(m_src_z), .m_ip_dest_ip(m_dst_z),
      .m_udp_source_port(m_sport_z), .m_udp_dest_port(m_dport_z),
      .m_udp_length(m_len_z), .m_udp_checksum(m_csum_z),
      .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
      .s_udp_payload_axis_tready(s_tready_z), .s_udp_payload_axis_tlast(s_tlast),
      .s_udp_payload_axis_tuser(s_tuser),
      .m_udp_payload_axis_tdata(m_tdata_z), .m_udp_payload_axis_tvalid(m_tvalid_z),
      .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(m_tlast_z),
      .m_udp_payload_axis_tuser(m_tuser_z),
      .error_checksum(err_c_z), .error_length(err_l_z), .busy(busy_z)
   );

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [15:0] len;
      int          n;
      logic [63:0] pl;       // first byte in bits 63:56
      int          bad_idx;  // byte replaced after the checksum is computed, -1 none
      logic [7:0]  bad_val;
      bit          zero_csum;
      bit          tuser_in;
      bit          rnd;
      bit          exp_ce;     // checksum error expected, ZERO_CSUM_OK=1
      bit          exp_ce_z0;  // checksum error expected, ZERO_CSUM_OK=0
      bit          exp_le;     // length error expected when length checking is built in
   } vec_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   typedef struct packed {
      logic ce;
      logic le;
      logic user_z0;
   } fres_t;

   logic [127:0] hdr_exp_q[$];
   beat_t        beat_q[$];
   fres_t        fres_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int frames_done = 0;
   bit rnd_mode = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] orig_byte(input vec_t v, input int i);
      return v.pl[63-8*i -: 8];
   endfunction

   function automatic logic [7:0] sent_byte(input vec_t v, input int i);
      return (i == v.bad_idx) ? v.bad_val : orig_byte(v, i);
   endfunction

   // Reference UDP checksum over the original (uncorrupted) payload
   function automatic logic [15:0] calc_csum(input vec_t v);
      logic [31:0] s;
      logic [7:0]  b;
      logic [15:0] c;
      s = 32'(v.src[31:16]) + 32'(v.src[15:0]) + 32'(v.dst[31:16]) + 32'(v.dst[15:0])
        + 32'h11 + 32'(v.len) + 32'(v.len) + 32'(v.sport) + 32'(v.dport);
      for (int i = 0; i < v.n; i++) begin
         b = orig_byte(v, i);
         s = s + (((i % 2) == 0) ? {16'h0, b, 8'h0} : {24'h0, b});
      end
      while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
      c = ~s[15:0];
      if (c == 16'h0) c = 16'hFFFF;
      return c;
   endfunction

   function automatic vec_t mk(input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] sp, input logic [15:0] dp,
                               input logic [15:0] len, input int n, input logic [63:0] pl,
                               input int bi, input logic [7:0] bv,
                               input bit zc, input bit tu, input bit rnd,
                               input bit ce, input bit cz, input bit le);
      vec_t v;
      v.src = src; v.dst = dst; v.sport = sp; v.dport = dp; v.len = len;
      v.n = n; v.pl = pl; v.bad_idx = bi; v.bad_val = bv;
      v.zero_csum = zc; v.tuser_in = tu; v.rnd = rnd;
      v.exp_ce = ce; v.exp_ce_z0 = cz; v.exp_le = le;
      return v;
   endfunction

   // Output-side ready generators
   initial begin
      m_tready    = 1'b1;
      m_hdr_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_tready    = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         m_hdr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard monitor
   initial begin
      int    ce_cnt;
      int    le_cnt;
      beat_t b;
      fres_t f;
      ce_cnt = 0;
      le_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ce_cnt = 0;
            le_cnt = 0;
         end else begin
            if (err_c) begin
               ce_cnt++;
               check("csum_pulse_align", 128'({m_tvalid, m_tlast}), 128'(2'b11));
            end
            if (err_l) le_cnt++;
            if (m_hdr_valid && m_hdr_ready) begin
               if (hdr_exp_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL hdr_unexpected: got header with no expectation (t=%0t)", $time);
               end else begin
                  check("hdr_fields", {m_src, m_dst, m_sport, m_dport, m_len, m_csum},
                        hdr_exp_q.pop_front());
               end
            end
            if (m_tvalid && m_tready) begin
               if (beat_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL beat_unexpected: got data %0h with no expectation (t=%0t)", m_tdata, $time);
               end else begin
                  b = beat_q.pop_front();
                  check("beat", 128'({m_tdata, m_tlast, m_tuser}), 128'(b));
               end
               if (m_tlast) begin
                  if (fres_q.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL frame_unexpected: tlast with no expectation (t=%0t)", $time);
                  end else begin
                     f = fres_q.pop_front();
                     check("err_checksum_pulses", 128'(ce_cnt), 128'(f.ce));
                     check("err_length_pulses", 128'(le_cnt), 128'(f.le));
                     check("tuser_zero_csum_strict", 128'(m_tuser_z), 128'(f.user_z0));
                  end
                  ce_cnt = 0;
                  le_cnt = 0;
                  frames_done++;
               end
            end
         end
      end
   end

   task automatic send_frame(input vec_t v, input int abort_after);
      logic [15:0] cs;
      int          cyc;
      int          start;
      bit          le_eff;
      beat_t       b;
      fres_t       f;
      cs     = v.zero_csum ? 16'h0000 : calc_csum(v);
      le_eff = LEN_EN && v.exp_le;
      rnd_mode = v.rnd;

      s_hdr_valid = 1'b1;
      s_src = v.src; s_dst = v.dst; s_sport = v.sport; s_dport = v.dport;
      s_len = v.len; s_csum = cs;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!s_hdr_ready && cyc < 100);
      check("hdr_ready", 128'(s_hdr_ready), 128'(1));

      hdr_exp_q.push_back({v.src, v.dst, v.sport, v.dport, v.len, cs});
      for (int i = 0; i < v.n; i++) begin
         b.data = sent_byte(v, i);
         b.last = (i == v.n - 1);
         b.user = (i == v.n - 1) && (v.tuser_in || v.exp_ce || le_eff);
         beat_q.push_back(b);
      end
      f.ce = v.exp_ce;
      f.le = le_eff;
      f.user_z0 = v.tuser_in || v.exp_ce_z0 || le_eff;
      fres_q.push_back(f);

      @(posedge clk); #1;
      s_hdr_valid = 1'b0;
      check("hdr_latency", 128'(m_hdr_valid), 128'(1));
      check("busy", 128'(busy), 128'(1));

      for (int i = 0; i < v.n; i++) begin
         if (abort_after >= 0 && i == abort_after) break;
         if (v.rnd) begin
            repeat ($urandom_range(0, 2)) begin
               s_tvalid = 1'b0;
               @(posedge clk); #1;
            end
         end
         s_tvalid = 1'b1;
         s_tdata  = sent_byte(v, i);
         s_tlast  = (i == v.n - 1);
         s_tuser  = (i == v.n - 1) && v.tuser_in;
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (!s_tready && cyc < 200);
         check("payload_ready", 128'(s_tready), 128'(1));
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      if (abort_after >= 0) return;

      start = frames_done;
      cyc = 0;
      while (frames_done == start && cyc < 200) begin @(negedge clk); cyc++; end
      check("frame_done", 128'(frames_done - start), 128'(1));
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 128'({m_hdr_valid, s_hdr_ready, s_tready, m_tvalid, m_tlast,
                                 m_tuser, err_c, err_l, busy}), 128'(0));
      check({tag, "_tdata"}, 128'(m_tdata), 128'(0));
      check({tag, "_hdr"}, {m_src, m_dst, m_sport, m_dport, m_len, m_csum}, 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      rst_n = 1'b0;
      s_hdr_valid = 1'b0; s_src = '0; s_dst = '0; s_sport = '0; s_dport = '0;
      s_len = '0; s_csum = '0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;

      //            src           dst           sport    dport    len   n  payload                 bad  val   zc tu rnd ce cz le
      vecs[0] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd12, 4, 64'h00010203_00000000, -1, 8'h00, 0, 0, 0, 0, 0, 0);
      vecs[1] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd12, 4, 64'h00010203_00000000,  2, 8'hFF, 0, 0, 0, 1, 1, 0);
      vecs[2] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd12, 4, 64'h00010203_00000000,  2, 8'hFF, 1, 0, 0, 0, 1, 0);
      vecs[3] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd13, 5, 64'h11223344_55000000, -1, 8'h00, 0, 0, 1, 0, 0, 0);
      vecs[4] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd20, 4, 64'h00010203_00000000, -1, 8'h00, 0, 0, 0, 0, 0, 1);
      vecs[5] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd12, 4, 64'h00010203_00000000, -1, 8'h00, 0, 1, 0, 0, 0, 0);
      vecs[6] = mk(32'h0A000001, 32'h0A0000FE, 16'd53,   16'd4000, 16'd7,  1, 64'hAB000000_00000000, -1, 8'h00, 0, 0, 0, 0, 0, 1);
      vecs[7] = mk(32'h0A000001, 32'h0A0000FE, 16'd53,   16'd4000, 16'd16, 8, 64'hDEADBEEF_CAFEF00D, -1, 8'h00, 0, 0, 1, 0, 0, 0);
      vecs[8] = mk(32'hC0A80164, 32'hC0A80101, 16'd1234, 16'd5678, 16'd12, 4, 64'h00010203_00000000, -1, 8'h00, 1, 0, 0, 0, 1, 0);

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) send_frame(vecs[i], -1);

      // Reset in the middle of a payload discards the frame
      send_frame(vecs[0], 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midframe_reset");
      hdr_exp_q.delete();
      beat_q.delete();
      fres_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      send_frame(vecs[0], -1);
      send_frame(vecs[3], -1);

      check("beat_queue_drained", 128'(beat_q.size()), 128'(0));
      check("frame_queue_drained", 128'(fres_q.size()), 128'(0));
      check("idle_at_end", 128'(busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_checksum_check.md
UDP_CHECKSUM_CHECK -- requirements
Module: udp_checksum_check

Interface
REQ-001 SHALL have parameter ZERO_CSUM_OK, default 1: when 1, a received udp_checksum of 0x0000 means "not transmitted" and is never flagged.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports s_udp_hdr_valid (input, 1) and s_udp_hdr_ready (output, 1): input header handshake.
REQ-005 SHALL have input ports s_ip_source_ip (32), s_ip_dest_ip (32), s_udp_source_port (16), s_udp_dest_port (16), s_udp_length (16) and s_udp_checksum (16): received header fields.
REQ-006 SHALL have ports m_udp_hdr_valid (output, 1) and m_udp_hdr_ready (input, 1): output header handshake.
REQ-007 SHALL have output ports m_ip_source_ip, m_ip_dest_ip, m_udp_source_port, m_udp_dest_port, m_udp_length and m_udp_checksum, each the same width as its s_ counterpart: registered copies of the header.
REQ-008 SHALL have payload input ports s_udp_payload_axis_tdata (input, 8), tvalid (input, 1), tready (output, 1), tlast (input, 1) and tuser (input, 1).
REQ-009 SHALL have payload output ports m_udp_payload_axis_tdata (output, 8), tvalid (output, 1), tready (input, 1), tlast (output, 1) and tuser (output, 1).
REQ-010 SHALL have port error_checksum, output, 1 bit: one-cycle pulse on a checksum mismatch.
REQ-011 SHALL have port error_length, output, 1 bit: one-cycle pulse on a length mismatch.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, HDR and PAYLOAD.
REQ-014 SHALL transition IDLE->HDR on s_udp_hdr_valid&&s_udp_hdr_ready; it SHALL latch all header fields in that cycle; s_udp_hdr_ready SHALL be 1 only in IDLE.
REQ-015 SHALL hold m_udp_hdr_valid high in HDR and SHALL transition HDR->PAYLOAD on m_udp_hdr_ready; header output latency is 1 cycle after acceptance.
REQ-016 SHALL drive s_udp_payload_axis_tready only in PAYLOAD, through a 1-entry output register: ready = !m_valid || m_tready.
REQ-017 SHALL pass tdata, tlast and tuser through with 1-cycle latency, with no data loss under arbitrary tready backpressure.
REQ-018 SHALL seed a 32-bit accumulator with src_ip[31:16] + src_ip[15:0] + dst_ip[31:16] + dst_ip[15:0] + 0x0011 + 2*udp_length + src_port + dst_port + udp_checksum.
REQ-019 SHALL add each accepted payload byte as the high byte of a 16-bit word when the byte index is even and as the low byte when odd; an odd-length payload is thereby zero-padded.
REQ-020 SHALL, on the accepted tlast beat, fold the accumulator (including that beat) twice into 16 bits; result != 0xFFFF is a checksum error, masked when ZERO_CSUM_OK=1 and udp_checksum=0.
REQ-021 SHALL, on the output tlast beat, drive m_udp_payload_axis_tuser = s tuser | checksum error | length error, and SHALL pulse the error outputs in that same cycle.
REQ-022 SHALL transition PAYLOAD->IDLE when the output tlast beat is accepted.
REQ-023 SHALL count payload bytes in a 16-bit counter that saturates at 0xFFFF.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state IDLE, all valid and ready outputs 0, error pulses 0, busy 0, accumulator and counter 0, and data/header outputs 0; a reset mid-frame discards the frame.

Configuration
REQ-025 SHALL, with UDP_CHECKSUM_CHECK_LEN_EN defined, flag a length error on tlast when byte count != udp_length-8 or udp_length<8; without the macro, error_length is tied to 0 and the length comparison is absent.

Structure
REQ-026 SHALL place the pseudo-header protocol constant 0x11, the UDP header length 8 and the FSM state enum in a shared package udp_pkg.
REQ-027 SHALL have one sub-module, ones_comp_fold, performing the 32->16 end-around-carry fold.

Verification
REQ-028 SHALL test: src 192.168.1.100, dst 192.168.1.1, ports 1234->5678, len 12, payload 00 01 02 03 with correct checksum -> tuser 0, no error pulses.
REQ-029 SHALL test: the same frame with payload byte 2 flipped to 0xFF -> tuser 1 on tlast and a single error_checksum pulse.
REQ-030 SHALL test: udp_checksum 0x0000 with a bad payload and ZERO_CSUM_OK=1 -> tuser 0; with ZERO_CSUM_OK=0 -> tuser 1.
REQ-031 SHALL test: a 5-byte odd payload with correct checksum under random m_tready -> tuser 0 and a byte-exact output stream.
REQ-032 SHALL test: with LEN_EN defined, len 20 and a 4-byte payload -> error_length pulse and tuser 1.
REQ-033 SHALL test: rst_n asserted after 2 payload bytes -> all outputs 0 immediately, and the next frame passes cleanly.
